// File: rtl/tdm_pkg.sv
// Shared constants, slot-width helper and slot type for the 4-slot TDM receive path.
// Default build has no LED output; define TDM_DEMUX_LED_EN to add it.
package tdm_pkg;

    localparam int NCH_DEF = 4;
    localparam int W_DEF   = 1;
    localparam int DIV_DEF = 1;

    function automatic int slot_w(input int n);
        return $clog2(n);
    endfunction

    typedef logic [slot_w(NCH_DEF)-1:0] slot_t;

endpackage

// File: rtl/tdm_demux4_if.sv
// Serial lane in, published frame and status pulses out; led exists only with TDM_DEMUX_LED_EN.
interface tdm_demux4_if
    import tdm_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int W   = W_DEF
);
    localparam int SW = slot_w(NCH);

    logic              en;
    logic [W-1:0]      din;
    logic              sync;
    logic [NCH*W-1:0]  ch;
    logic [SW-1:0]     sel;
    logic              frame_valid;
    logic              sync_err;
`ifdef TDM_DEMUX_LED_EN
    logic [15:0]       led;

    modport master (output en, din, sync, input ch, sel, frame_valid, sync_err, led);
    modport slave  (input en, din, sync, output ch, sel, frame_valid, sync_err, led);
`else
    modport master (output en, din, sync, input ch, sel, frame_valid, sync_err);
    modport slave  (input en, din, sync, output ch, sel, frame_valid, sync_err);
`endif

endinterface

// File: rtl/tdm_tick_gen.sv
// Slot prescaler: counts enabled cycles 0..DIV-1 and flags the last one as a slot tick.
// en low freezes the count; tick is combinational from the count and en.
module tdm_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_tick
);
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign o_tick = i_en && w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// TDM receiver: steers one lane sample per slot tick into a shadow frame and publishes it on the last slot.
// Optional TDM_DEMUX_LED_EN adds a 16-bit LED ring that rotates once per published frame.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int W   = W_DEF,
    parameter int DIV = DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    tdm_demux4_if.slave bus
);
    localparam int            SW   = slot_w(NCH);
    localparam logic [SW-1:0] LAST = SW'(NCH - 1);

    logic                  w_tick;
    logic                  w_misalign;
    logic                  w_publish;
    logic [SW-1:0]         r_sel;
    logic [(NCH-1)*W-1:0]  r_shadow;
    logic [NCH*W-1:0]      r_ch;
    logic                  r_fv;
    logic                  r_err;

    tdm_tick_gen #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .i_en   (bus.en),
        .o_tick (w_tick)
    );

    // An aligned sync (at slot 0) is indistinguishable from a normal tick.
    assign w_misalign = bus.sync && (r_sel != '0);
    assign w_publish  = w_tick && !w_misalign && (r_sel == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel    <= '0;
            r_shadow <= '0;
            r_ch     <= '0;
            r_fv     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_fv  <= 1'b0;
            r_err <= 1'b0;
            if (w_tick) begin
                if (w_misalign) begin
                    r_shadow[W-1:0] <= bus.din;
                    r_sel           <= SW'(1);
                    r_err           <= 1'b1;
                end else if (r_sel == LAST) begin
                    r_ch  <= {bus.din, r_shadow};
                    r_sel <= '0;
                    r_fv  <= 1'b1;
                end else begin
                    r_shadow[int'(r_sel)*W +: W] <= bus.din;
                    r_sel                        <= r_sel + 1'b1;
                end
            end
        end
    end

    assign bus.ch          = r_ch;
    assign bus.sel         = r_sel;
    assign bus.frame_valid = r_fv;
    assign bus.sync_err    = r_err;

`ifdef TDM_DEMUX_LED_EN
    logic [15:0] r_led;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led <= 16'h0001;
        end else if (w_publish) begin
            r_led <= {r_led[14:0], r_led[15]};
        end
    end

    assign bus.led = r_led;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: a DIV=1 instance against a frame-level model, plus a DIV=3 instance.
module tb_tdm_demux4;
    import tdm_pkg::*;

    localparam int TN = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    tdm_demux4_if #(.NCH(TN), .W(1)) bus1 ();
    tdm_demux4_if #(.NCH(TN), .W(1)) bus3 ();

    tdm_demux4 #(.NCH(TN), .W(1), .DIV(1)) dut  (.clk(clk), .rst(rst), .bus(bus1));
    tdm_demux4 #(.NCH(TN), .W(1), .DIV(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    // Reference: where the next sample lands, what each channel holds, what was last published.
    int          m_slot;
    logic        m_sh[TN];
    logic [3:0]  m_ch;
    logic        m_fv;
    logic        m_err;
    logic [15:0] m_led;

    task automatic model_reset();
        m_slot = 0;
        for (int k = 0; k < TN; k++) m_sh[k] = 1'b0;
        m_ch  = '0;
        m_fv  = 1'b0;
        m_err = 1'b0;
        m_led = 16'h0001;
    endtask

    task automatic model_edge(input logic en, input logic din, input logic sync);
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (en) begin
            if (sync && m_slot != 0) begin
                m_sh[0] = din;
                m_slot  = 1;
                m_err   = 1'b1;
            end else begin
                m_sh[m_slot] = din;
                if (m_slot == TN - 1) begin
                    for (int k = 0; k < TN; k++) m_ch[k] = m_sh[k];
                    m_fv   = 1'b1;
                    m_slot = 0;
                    m_led  = {m_led[14:0], m_led[15]};
                end else begin
                    m_slot++;
                end
            end
        end
    endtask

    function automatic logic [7:0] obs1();
        return {bus1.ch, bus1.sel, bus1.frame_valid, bus1.sync_err};
    endfunction

    function automatic logic [7:0] exp1();
        return {m_ch, slot_t'(m_slot), m_fv, m_err};
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, settle 1 ns past it.
    task automatic step(input logic en, input logic din, input logic sync);
        bus1.en   = en;
        bus1.din  = din;
        bus1.sync = sync;
        @(posedge clk);
        model_edge(en, din, sync);
        #1;
    endtask

    task automatic test_reset();
        bus1.en = 1'b1; bus1.din = 1'b1; bus1.sync = 1'b0;
        bus3.en = 1'b0; bus3.din = 1'b0; bus3.sync = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (obs1() !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=%h", obs1(), 8'h00);
        end
        checks++;
`ifdef TDM_DEMUX_LED_EN
        if (bus1.led !== 16'h0001) begin
            errors++;
            $display("FAIL reset_led got=%h exp=%h", bus1.led, 16'h0001);
        end
        checks++;
`endif
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic_frame();
        logic [3:0] pat;
        pat = 4'b1101;
        for (int i = 0; i < TN; i++) begin
            step(1'b1, pat[i], 1'b0);
            if (obs1() !== exp1()) begin
                errors++;
                $display("FAIL basic_model i=%0d got=%h exp=%h", i, obs1(), exp1());
            end
            checks++;
        end
        if ({bus1.frame_valid, bus1.ch, bus1.sel} !== {1'b1, pat, 2'd0}) begin
            errors++;
            $display("FAIL basic_frame got fv=%b ch=%b sel=%0d exp fv=1 ch=%b sel=0",
                     bus1.frame_valid, bus1.ch, bus1.sel, pat);
        end
        checks++;
    endtask

    task automatic test_random_frames();
        int nfv = 0;
        for (int i = 0; i < 48; i++) begin
            step(1'b1, 1'($urandom), (m_slot == 0) ? 1'($urandom) : 1'b0);
            if (obs1() !== exp1()) begin
                errors++;
                $display("FAIL rand_frames i=%0d got=%h exp=%h", i, obs1(), exp1());
            end
            checks++;
            if (bus1.frame_valid === 1'b1) nfv++;
        end
        if (nfv != 12) begin
            errors++;
            $display("FAIL rand_frames_count got=%0d exp=12", nfv);
        end
        checks++;
    endtask

    task automatic test_sync_err();
        logic [3:0] ch_before;
        step(1'b1, 1'($urandom), 1'b0);
        step(1'b1, 1'($urandom), 1'b0);
        ch_before = m_ch;
        step(1'b1, 1'b1, 1'b1);
        if ({bus1.sync_err, bus1.frame_valid, bus1.sel, bus1.ch} !== {1'b1, 1'b0, 2'd1, ch_before}) begin
            errors++;
            $display("FAIL sync_err_pulse got err=%b fv=%b sel=%0d ch=%b exp err=1 fv=0 sel=1 ch=%b",
                     bus1.sync_err, bus1.frame_valid, bus1.sel, bus1.ch, ch_before);
        end
        checks++;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'($urandom), 1'b0);
            if (obs1() !== exp1()) begin
                errors++;
                $display("FAIL sync_err_follow i=%0d got=%h exp=%h", i, obs1(), exp1());
            end
            checks++;
        end
        if ({bus1.frame_valid, bus1.ch[0]} !== 2'b11) begin
            errors++;
            $display("FAIL sync_err_refill got fv=%b ch0=%b exp fv=1 ch0=1", bus1.frame_valid, bus1.ch[0]);
        end
        checks++;
    endtask

    task automatic test_rst_mid();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        if (obs1() !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_immediate got=%h exp=%h", obs1(), 8'h00);
        end
        checks++;
        #1;
        rst = 1'b0;
        model_reset();
        step(1'b1, 1'b1, 1'b0);
        if (bus1.sel !== 2'd1) begin
            errors++;
            $display("FAIL rst_mid_restart got sel=%0d exp=1", bus1.sel);
        end
        checks++;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'($urandom), 1'b0);
            if (obs1() !== exp1()) begin
                errors++;
                $display("FAIL rst_mid_frame i=%0d got=%h exp=%h", i, obs1(), exp1());
            end
            checks++;
        end
    endtask

    task automatic test_en_freeze();
        logic [7:0] frozen;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        frozen = exp1();
        frozen[1:0] = 2'b00;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'($urandom), 1'($urandom));
            if (obs1() !== frozen) begin
                errors++;
                $display("FAIL en_freeze i=%0d got=%h exp=%h", i, obs1(), frozen);
            end
            checks++;
        end
        step(1'b1, 1'b0, 1'b0);
        if (bus1.sel !== 2'd3) begin
            errors++;
            $display("FAIL en_resume got sel=%0d exp=3", bus1.sel);
        end
        checks++;
    endtask

    task automatic test_random_mix();
        for (int i = 0; i < 300; i++) begin
            step(($urandom % 4) != 0, 1'($urandom), ($urandom % 8) == 0);
            if (obs1() !== exp1() || (bus1.frame_valid && bus1.sync_err)) begin
                errors++;
                $display("FAIL rand_mix i=%0d got=%h exp=%h", i, obs1(), exp1());
            end
            checks++;
        end
    endtask

    task automatic test_div3();
        int         cnt3 = 0, slot3 = 0, npulse = 0, last_pulse = -1;
        logic       q3[$];
        logic [3:0] e3_ch = '0;
        logic       e3_fv;
        bus1.en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus3.en = 1'b1; bus3.sync = 1'b0;
        for (int c = 0; c < 72; c++) begin
            bus3.din = 1'($urandom);
            @(posedge clk);
            e3_fv = 1'b0;
            if (cnt3 == 2) begin
                cnt3 = 0;
                q3.push_back(bus3.din);
                slot3 = (slot3 + 1) % TN;
                if (slot3 == 0) begin
                    e3_fv = 1'b1;
                    for (int k = 0; k < TN; k++) e3_ch[k] = q3[q3.size() - TN + k];
                end
            end else begin
                cnt3++;
            end
            #1;
            if ({bus3.ch, bus3.sel, bus3.frame_valid, bus3.sync_err} !== {e3_ch, slot_t'(slot3), e3_fv, 1'b0}) begin
                errors++;
                $display("FAIL div3 c=%0d got ch=%b sel=%0d fv=%b err=%b exp ch=%b sel=%0d fv=%b err=0",
                         c, bus3.ch, bus3.sel, bus3.frame_valid, bus3.sync_err, e3_ch, slot3, e3_fv);
            end
            checks++;
            if (bus3.frame_valid === 1'b1) begin
                if (last_pulse >= 0 && c - last_pulse != 12) begin
                    errors++;
                    $display("FAIL div3_period got=%0d exp=12", c - last_pulse);
                end
                checks++;
                last_pulse = c;
                npulse++;
            end
        end
        if (npulse != 6) begin
            errors++;
            $display("FAIL div3_pulse_count got=%0d exp=6", npulse);
        end
        checks++;
        bus3.en = 1'b0;
        model_reset();
    endtask

`ifdef TDM_DEMUX_LED_EN
    task automatic test_led();
        logic [15:0] want;
        for (int f = 0; f < 16; f++) begin
            for (int s = 0; s < TN; s++) step(1'b1, 1'($urandom), 1'b0);
            want = 16'h0001 << ((f + 1) % 16);
            if (bus1.led !== want || bus1.led !== m_led) begin
                errors++;
                $display("FAIL led_rotate f=%0d got=%h exp=%h", f, bus1.led, want);
            end
            checks++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_random_frames();
        test_sync_err();
        test_rst_mid();
        test_en_freeze();
        test_random_mix();
        test_div3();
`ifdef TDM_DEMUX_LED_EN
        test_led();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
